// File: rtl/window_pkg.sv
// Shared pixel, coordinate and window types plus default frame geometry
// used by the window generator and the Sobel edge stage.
package window_pkg;

   typedef logic [3:0] pixel_t;
   typedef logic [9:0] xcoord_t;
   typedef logic [8:0] ycoord_t;

   // [r][c]: r=0 is the top row (y-2), c=0 is the left column (x-2)
   typedef pixel_t [0:2][0:2] window_t;

   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int DEF_MIN_GAP    = 6;

endpackage

// File: rtl/linebuf_ram.sv
// Simple dual-port line RAM: one write port and one registered read port.
// No reset on the array so it maps onto block RAM.
module linebuf_ram #(
   parameter int DEPTH = 640,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/window_gen.sv
// Builds paced 3x3 pixel windows from a raster pixel stream using a
// two-line buffer, a column shift register and a one-entry pending slot.
module window_gen
   import window_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int MIN_GAP    = DEF_MIN_GAP
) (
   input  logic    clk,
   input  logic    nreset,
   input  pixel_t  i_pix,
   input  logic    i_pix_valid,
   input  xcoord_t i_pix_x,
   input  ycoord_t i_pix_y,
   output window_t o_win,
   output logic    o_win_valid,
   output xcoord_t o_win_x,
   output ycoord_t o_win_y,
   output logic    o_overflow
);

   // Input is valid-only (no ready): a pixel is taken on every cycle where
   // i_pix_valid is high; o_win_valid is a one-cycle pulse, data held after.
   localparam int      AW        = $clog2(IMG_WIDTH);
   localparam int      GW        = $clog2(MIN_GAP + 1);
   localparam xcoord_t LP_WIDTH  = xcoord_t'(IMG_WIDTH);
   localparam ycoord_t LP_HEIGHT = ycoord_t'(IMG_HEIGHT);
   localparam logic [GW-1:0] LP_RELOAD = GW'(MIN_GAP - 1);

   logic          w_accept;
   logic [7:0]    w_rd;
   window_t       w_shift;
   logic          w_complete, w_gap_zero;
   logic          w_emit_pend, w_emit_new, w_store, w_drop;

   logic          r_s1_valid;
   pixel_t        r_s1_pix;
   xcoord_t       r_s1_x;
   ycoord_t       r_s1_y;
   window_t       r_win_sh;
   logic [GW-1:0] r_gap;
   logic          r_pend_valid;
   window_t       r_pend_win;
   xcoord_t       r_pend_x;
   ycoord_t       r_pend_y;
   window_t       r_win;
   logic          r_win_valid;
   xcoord_t       r_win_x;
   ycoord_t       r_win_y;
   logic          r_overflow;

   assign w_accept = i_pix_valid && (i_pix_x < LP_WIDTH) && (i_pix_y < LP_HEIGHT);

   linebuf_ram #(.DEPTH(IMG_WIDTH), .AW(AW)) u_linebuf (
      .clk     (clk),
      .i_we    (r_s1_valid),
      .i_waddr (r_s1_x[AW-1:0]),
      .i_wdata ({w_rd[3:0], r_s1_pix}),
      .i_re    (w_accept),
      .i_raddr (i_pix_x[AW-1:0]),
      .o_rdata (w_rd)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_s1_valid <= 1'b0;
         r_s1_pix   <= '0;
         r_s1_x     <= '0;
         r_s1_y     <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_pix <= i_pix;
            r_s1_x   <= i_pix_x;
            r_s1_y   <= i_pix_y;
         end
      end
   end

   // New right column is {line y-2, line y-1, current pixel}
   always_comb begin
      w_shift = r_win_sh;
      for (int r = 0; r < 3; r++) begin
         w_shift[r][0] = r_win_sh[r][1];
         w_shift[r][1] = r_win_sh[r][2];
      end
      w_shift[0][2] = w_rd[7:4];
      w_shift[1][2] = w_rd[3:0];
      w_shift[2][2] = r_s1_pix;
   end

   // The pending entry always leaves first; a new window then takes its slot.
   always_comb begin
      w_complete  = r_s1_valid && (r_s1_x >= xcoord_t'(2)) && (r_s1_y >= ycoord_t'(2));
      w_gap_zero  = (r_gap == '0);
      w_emit_pend = w_gap_zero && r_pend_valid;
      w_emit_new  = w_gap_zero && !r_pend_valid && w_complete;
      w_store     = w_complete && (w_emit_pend || (!w_gap_zero && !r_pend_valid));
      w_drop      = w_complete && !w_gap_zero && r_pend_valid;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_win_sh     <= '0;
         r_gap        <= '0;
         r_pend_valid <= 1'b0;
         r_pend_win   <= '0;
         r_pend_x     <= '0;
         r_pend_y     <= '0;
         r_win        <= '0;
         r_win_valid  <= 1'b0;
         r_win_x      <= '0;
         r_win_y      <= '0;
         r_overflow   <= 1'b0;
      end else begin
         if (r_s1_valid) r_win_sh <= w_shift;

         r_win_valid <= w_emit_pend || w_emit_new;
         if (w_emit_pend) begin
            r_win   <= r_pend_win;
            r_win_x <= r_pend_x;
            r_win_y <= r_pend_y;
         end else if (w_emit_new) begin
            r_win   <= w_shift;
            r_win_x <= r_s1_x - xcoord_t'(1);
            r_win_y <= r_s1_y - ycoord_t'(1);
         end

         if (w_emit_pend || w_emit_new) r_gap <= LP_RELOAD;
         else if (!w_gap_zero)          r_gap <= r_gap - GW'(1);

         if (w_emit_pend)  r_pend_valid <= w_complete;
         else if (w_store) r_pend_valid <= 1'b1;
         if (w_store) begin
            r_pend_win <= w_shift;
            r_pend_x   <= r_s1_x - xcoord_t'(1);
            r_pend_y   <= r_s1_y - ycoord_t'(1);
         end

         if (w_drop) r_overflow <= 1'b1;
         else if (w_accept && (i_pix_x == '0) && (i_pix_y == '0)) r_overflow <= 1'b0;
      end
   end

   assign o_win       = r_win;
   assign o_win_valid = r_win_valid;
   assign o_win_x     = r_win_x;
   assign o_win_y     = r_win_y;
   assign o_overflow  = r_overflow;

endmodule
